// File: rtl/alink_txc_rr_pkg.sv
// Shared defaults and FSM encoding for the alink TX dispatch arbiter.
package alink_txc_rr_pkg;

  localparam int PHY_NUM_DEF = 32;
  localparam int TW_DEF      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/alink_txc_rr_pick.sv
// Combinational channel picker: round-robin from ptr (wrapping) or fixed
// priority with the lowest index winning.
module alink_txc_rr_pick #(
  parameter int PHY_NUM = 32,
  parameter bit RR_EN   = 1'b1
) (
  input  logic [PHY_NUM-1:0]         elig,
  input  logic [$clog2(PHY_NUM)-1:0] ptr,
  output logic [PHY_NUM-1:0]         grant,
  output logic [$clog2(PHY_NUM)-1:0] grant_idx
);

  localparam int IW = $clog2(PHY_NUM);

  logic found;
  int   idx;

  // NOTE: every output and temporary gets a default before the search loop;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < PHY_NUM; k++) begin
      idx = RR_EN ? (int'(ptr) + k) % PHY_NUM : k;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alink_txc_rr.sv
// TX dispatch arbiter: hands FIFO tasks to idle unmasked PHY channels and
// tracks per-channel busy state with a response timeout.
module alink_txc_rr
  import alink_txc_rr_pkg::*;
#(
  parameter int PHY_NUM = PHY_NUM_DEF,
  parameter int TW      = TW_DEF,
  parameter bit RR_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_flush,
  input  logic [PHY_NUM-1:0]    reg_mask,
  input  logic [TW-1:0]         reg_tout,
  input  logic                  tx_task_vld,
  output logic                  tx_phy_start,
  output logic [PHY_NUM-1:0]    tx_phy_sel,
  input  logic                  tx_phy_done,
  input  logic [PHY_NUM-1:0]    rx_done,
  input  logic [PHY_NUM-1:0]    tout_clr,
  output logic [PHY_NUM-1:0]    reg_busy,
  output logic [PHY_NUM-1:0]    tout_flag,
  output logic [TW*PHY_NUM-1:0] timer_cnt,
  output logic [1:0]            cur_state
);

  localparam int IW = $clog2(PHY_NUM);

  state_e             state_q;
  logic               start_q;
  logic [PHY_NUM-1:0] sel_q;
  logic [IW-1:0]      sel_idx_q;
  logic [IW-1:0]      ptr_q;

  logic [PHY_NUM-1:0] busy_vec;
  logic [PHY_NUM-1:0] flag_vec;
  logic [PHY_NUM-1:0] elig;
  logic [PHY_NUM-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic [PHY_NUM-1:0] busy_set;

  assign elig     = ~reg_mask & ~busy_vec;
  assign busy_set = (state_q == WAIT && tx_phy_done) ? sel_q : '0;

  alink_txc_rr_pick #(
    .PHY_NUM (PHY_NUM),
    .RR_EN   (RR_EN)
  ) u_pick (
    .elig      (elig),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || reg_flush) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      sel_q     <= '0;
      sel_idx_q <= '0;
      ptr_q     <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_task_vld && |elig) begin
            sel_q     <= grant;
            sel_idx_q <= grant_idx;
            start_q   <= 1'b1;
            state_q   <= START;
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (tx_phy_done) begin
            ptr_q   <= (sel_idx_q == IW'(PHY_NUM - 1)) ? '0 : sel_idx_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < PHY_NUM; i++) begin : g_ch
    logic          busy_q;
    logic          flag_q;
    logic [TW-1:0] timer_q;
    logic          expire;

    // Expiry is the 1 -> 0 step; a new dispatch or a report on the same
    // cycle takes precedence and suppresses the flag.
    assign expire = !busy_set[i] && !rx_done[i] && busy_q && (timer_q == TW'(1));

    always_ff @(posedge clk) begin
      if (rst || reg_flush) begin
        busy_q  <= 1'b0;
        flag_q  <= 1'b0;
        timer_q <= '0;
      end else begin
        if (busy_set[i]) begin
          busy_q  <= 1'b1;
          timer_q <= reg_tout;
        end else if (rx_done[i] && busy_q) begin
          busy_q  <= 1'b0;
          timer_q <= '0;
        end else if (expire) begin
          busy_q  <= 1'b0;
          timer_q <= '0;
        end else if (busy_q && timer_q != '0) begin
          timer_q <= timer_q - 1'b1;
        end

        if (expire)           flag_q <= 1'b1;
        else if (tout_clr[i]) flag_q <= 1'b0;
      end
    end

    assign busy_vec[i]             = busy_q;
    assign flag_vec[i]             = flag_q;
    assign timer_cnt[TW*i +: TW]   = timer_q;
  end

  assign tx_phy_start = start_q;
  assign tx_phy_sel   = sel_q;
  assign reg_busy     = busy_vec;
  assign tout_flag    = flag_vec;
  assign cur_state    = state_q;

endmodule

// File: tb/tb_alink_txc_rr.sv
// Bench: a round-robin and a fixed-priority instance driven in lockstep,
// checked every cycle against a rule-level model plus directed literals.
module tb_alink_txc_rr;

  localparam int N  = 4;
  localparam int TW = 8;

  logic clk;
  logic rst;
  logic reg_flush;
  logic [N-1:0]  reg_mask;
  logic [TW-1:0] reg_tout;
  logic tx_task_vld;
  logic tx_phy_done;
  logic [N-1:0] rx_done;
  logic [N-1:0] tout_clr;

  logic            start_o [2];
  logic [N-1:0]    sel_o   [2];
  logic [N-1:0]    busy_o  [2];
  logic [N-1:0]    flag_o  [2];
  logic [TW*N-1:0] timer_o [2];
  logic [1:0]      state_o [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  alink_txc_rr #(.PHY_NUM(N), .TW(TW), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_mask(reg_mask),
    .reg_tout(reg_tout), .tx_task_vld(tx_task_vld), .tx_phy_start(start_o[0]),
    .tx_phy_sel(sel_o[0]), .tx_phy_done(tx_phy_done), .rx_done(rx_done),
    .tout_clr(tout_clr), .reg_busy(busy_o[0]), .tout_flag(flag_o[0]),
    .timer_cnt(timer_o[0]), .cur_state(state_o[0])
  );

  alink_txc_rr #(.PHY_NUM(N), .TW(TW), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_mask(reg_mask),
    .reg_tout(reg_tout), .tx_task_vld(tx_task_vld), .tx_phy_start(start_o[1]),
    .tx_phy_sel(sel_o[1]), .tx_phy_done(tx_phy_done), .rx_done(rx_done),
    .tout_clr(tout_clr), .reg_busy(busy_o[1]), .tout_flag(flag_o[1]),
    .timer_cnt(timer_o[1]), .cur_state(state_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: d=0 round-robin, d=1 fixed priority ----------------
  int m_phase [2];          // 0 idle, 1 start, 2 wait
  int m_sel   [2];          // -1 = nothing selected yet
  int m_ptr   [2];
  bit m_busy  [2][N];
  bit m_flag  [2][N];
  int m_timer [2][N];

  task automatic model_step(input int d);
    bit old_busy [N];
    int setc;
    int pick;
    int idx;
    bit exp_now;
    if (rst || reg_flush) begin
      m_phase[d] = 0; m_sel[d] = -1; m_ptr[d] = 0;
      for (int i = 0; i < N; i++) begin
        m_busy[d][i] = 0; m_flag[d][i] = 0; m_timer[d][i] = 0;
      end
      return;
    end
    for (int i = 0; i < N; i++) old_busy[i] = m_busy[d][i];
    setc = (m_phase[d] == 2 && tx_phy_done) ? m_sel[d] : -1;
    for (int i = 0; i < N; i++) begin
      exp_now = 0;
      if (i == setc) begin
        m_busy[d][i] = 1; m_timer[d][i] = int'(reg_tout);
      end else if (rx_done[i] && old_busy[i]) begin
        m_busy[d][i] = 0; m_timer[d][i] = 0;
      end else if (old_busy[i] && m_timer[d][i] == 1) begin
        m_busy[d][i] = 0; m_timer[d][i] = 0; exp_now = 1;
      end else if (old_busy[i] && m_timer[d][i] > 1) begin
        m_timer[d][i] = m_timer[d][i] - 1;
      end
      if (exp_now) m_flag[d][i] = 1;
      else if (tout_clr[i]) m_flag[d][i] = 0;
    end
    case (m_phase[d])
      0: if (tx_task_vld) begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          idx = (d == 0) ? (m_ptr[d] + k) % N : k;
          if (pick < 0 && !reg_mask[idx] && !old_busy[idx]) pick = idx;
        end
        if (pick >= 0) begin m_sel[d] = pick; m_phase[d] = 1; end
      end
      1: m_phase[d] = 2;
      default: if (tx_phy_done) begin
        m_ptr[d] = (m_sel[d] + 1) % N; m_phase[d] = 0;
      end
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d_start", d), 32'(start_o[d]), 32'(m_phase[d] == 1));
        check($sformatf("d%0d_state", d), 32'(state_o[d]), 32'(m_phase[d]));
        check($sformatf("d%0d_sel", d), 32'(sel_o[d]),
              (m_sel[d] < 0) ? 32'd0 : (32'd1 << m_sel[d]));
        for (int i = 0; i < N; i++) begin
          check($sformatf("d%0d_busy%0d", d, i), 32'(busy_o[d][i]), 32'(m_busy[d][i]));
          check($sformatf("d%0d_flag%0d", d, i), 32'(flag_o[d][i]), 32'(m_flag[d][i]));
          check($sformatf("d%0d_timer%0d", d, i), 32'(timer_o[d][TW*i +: TW]),
                32'(m_timer[d][i]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start(input int max_cyc, input string name);
    bit got;
    got = 0;
    for (int n = 0; n < max_cyc && !got; n++) begin
      step();
      if (start_o[0]) got = 1;
    end
    check({name, "_start_seen"}, 32'(got), 32'd1);
  endtask

  // Runs one full dispatch: wait for start, then complete it with tx_phy_done.
  task automatic dispatch(input string name);
    tx_task_vld = 1'b1;
    wait_start(8, name);
    tx_task_vld = 1'b0;
    step();
    tx_phy_done = 1'b1;
    step();
    tx_phy_done = 1'b0;
  endtask

  logic [N-1:0] rr_exp [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;
    rst = 1'b1; reg_flush = 1'b0; reg_mask = 4'b0010; reg_tout = '0;
    tx_task_vld = 1'b1; tx_phy_done = 1'b0; rx_done = '0; tout_clr = '0;

    // Reset with a task pending: nothing may be dispatched.
    step();
    cmp_en = 1;
    check("rst_start", 32'(start_o[0] | start_o[1]), 32'd0);
    step();
    check("rst_busy", 32'(busy_o[0] | busy_o[1]), 32'd0);
    check("rst_sel", 32'(sel_o[0] | sel_o[1]), 32'd0);
    rst = 1'b0;

    // Selection order with channel 1 masked; report returns right after done.
    for (int t = 0; t < 4; t++) begin
      tx_task_vld = 1'b1;
      wait_start(8, "seq");
      check($sformatf("rr_sel%0d", t), 32'(sel_o[0]), 32'(rr_exp[t]));
      check($sformatf("fp_sel%0d", t), 32'(sel_o[1]), 32'd1);
      tx_task_vld = 1'b0;
      step();
      tx_phy_done = 1'b1;
      step();
      tx_phy_done = 1'b0; rx_done = 4'b1111;
      step();
      rx_done = '0;
    end

    // Timeout of 5 on channel 2: expiry 5 cycles after the done cycle.
    reg_mask = 4'b1011; reg_tout = 8'd5;
    dispatch("tout");
    check("tout_load", 32'(timer_o[0][TW*2 +: TW]), 32'd5);
    for (int c = 0; c < 4; c++) step();
    check("tout_busy_hold", 32'(busy_o[0][2]), 32'd1);
    step();
    check("tout_busy_clr", 32'(busy_o[0][2]), 32'd0);
    check("tout_flag_set", 32'(flag_o[0][2]), 32'd1);
    tout_clr = 4'b0100;
    step();
    tout_clr = '0;
    check("tout_flag_clr", 32'(flag_o[0][2]), 32'd0);

    // Report arriving on the expiry cycle wins: no flag.
    reg_tout = 8'd3;
    dispatch("race");
    step();
    step();
    rx_done = 4'b0100;
    step();
    rx_done = '0;
    check("race_busy", 32'(busy_o[0][2]), 32'd0);
    check("race_flag", 32'(flag_o[0][2] | flag_o[1][2]), 32'd0);

    // Flush while a dispatch is in WAIT, with another channel busy.
    reg_tout = 8'd200;
    dispatch("fl_a");
    reg_mask = '0;
    tx_task_vld = 1'b1;
    wait_start(8, "fl_b");
    tx_task_vld = 1'b0;
    step();
    reg_flush = 1'b1;
    step();
    reg_flush = 1'b0;
    check("flush_state", 32'(state_o[0]), 32'd0);
    check("flush_busy", 32'(busy_o[0] | busy_o[1]), 32'd0);
    check("flush_timer", timer_o[0] | timer_o[1], 32'd0);

    // All channels busy: no start until channel 1 reports back.
    reg_tout = '0;
    for (int t = 0; t < 4; t++) dispatch("fill");
    check("all_busy", 32'(busy_o[0] & busy_o[1]), 32'hF);
    tx_task_vld = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("blocked_start", 32'(start_o[0] | start_o[1]), 32'd0);
    end
    rx_done = 4'b0010;
    step();
    rx_done = '0;
    wait_start(2, "unblock");
    check("unblock_rr_sel", 32'(sel_o[0]), 32'h2);
    check("unblock_fp_sel", 32'(sel_o[1]), 32'h2);
    tx_task_vld = 1'b0;
    for (int c = 0; c < 4; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
